// File: rtl/cond_pkg.sv
// -----------------------------------------------------------------------------
// cond_pkg
// Shared definitions for the conditional-execution unit:
//   - cond_e        : 4-bit condition codes (EQ..AL, 15 behaves as AL)
//   - FLAG_*        : bit positions of N/Z/C/V inside a 4-bit flag word
//   - FGRP_*        : bit positions of the two update groups inside flag_w
//   - apply_flag_write : merges ALU flags into a flag word per group enables
// -----------------------------------------------------------------------------
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Group enables inside flag_w: NZ group uses bit 1, CV group uses bit 0.
    localparam int FGRP_NZ = 1;
    localparam int FGRP_CV = 0;

    // Each group is replaced independently; a disabled group keeps old bits.
    function automatic logic [3:0] apply_flag_write(input logic [3:0] old_flags,
                                                    input logic [3:0] alu_flags,
                                                    input logic [1:0] flag_w);
        logic [3:0] res;
        res = old_flags;
        if (flag_w[FGRP_NZ]) begin
            res[FLAG_N] = alu_flags[FLAG_N];
            res[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (flag_w[FGRP_CV]) begin
            res[FLAG_C] = alu_flags[FLAG_C];
            res[FLAG_V] = alu_flags[FLAG_V];
        end
        return res;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational condition-code evaluator.
// Ports:
//   cond    in  4  condition code (cond_e)
//   flags   in  4  {N,Z,C,V}
//   cond_ex out 1  1 when the condition holds for the given flags
// -----------------------------------------------------------------------------
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        // NOTE: assign a default before the case so no path leaves cond_ex
        // unassigned; otherwise synthesis infers a latch.
        cond_ex = 1'b1;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            default: cond_ex = 1'b1;   // AL and the unused encoding 15
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// -----------------------------------------------------------------------------
// cond_exec_unit
// Multi-context conditional-execution unit. Holds one NZCV flag word per
// context, evaluates an instruction's condition against its context's flags,
// gates branch/regwrite/memwrite requests and registers the results with one
// cycle of latency. Flag updates from executed instructions are visible to
// the next cycle's instruction. A direct load port restores a context's flags
// and wins over a same-cycle instruction write to the same context.
// Per-context saturating counters track executed and squashed instructions.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, ctx_id, cond   instruction present / its context / condition
//   alu_flags, flag_w        ALU result flags and NZ/CV group write enables
//   pcs, reg_w, mem_w        unconditioned branch/regwrite/memwrite requests
//   ld_en, ld_ctx, ld_flags  flag restore port
//   cnt_clr                  clear all counters
//   out_valid, cond_ex, pc_src, reg_write, mem_write   registered results
//   flags_rd                 current flags of ctx_id (combinational)
//   exec_cnt, squash_cnt     packed per-context counters, context 0 in LSBs
// Contexts >= NUM_CTX are ignored: no state change and cond_ex forced to 0.
// -----------------------------------------------------------------------------
module cond_exec_unit
    import cond_pkg::*;
#(
    parameter  int NUM_CTX = 4,
    parameter  int CNT_W   = 16,
    localparam int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [CTX_W-1:0]         ctx_id,
    input  logic [3:0]               cond,
    input  logic [3:0]               alu_flags,
    input  logic [1:0]               flag_w,
    input  logic                     pcs,
    input  logic                     reg_w,
    input  logic                     mem_w,
    input  logic                     ld_en,
    input  logic [CTX_W-1:0]         ld_ctx,
    input  logic [3:0]               ld_flags,
    input  logic                     cnt_clr,
    output logic                     out_valid,
    output logic                     pc_src,
    output logic                     reg_write,
    output logic                     mem_write,
    output logic                     cond_ex,
    output logic [3:0]               flags_rd,
    output logic [NUM_CTX*CNT_W-1:0] exec_cnt,
    output logic [NUM_CTX*CNT_W-1:0] squash_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]       flags_q  [NUM_CTX];
    logic [3:0]       flags_d  [NUM_CTX];
    logic [CNT_W-1:0] exec_q   [NUM_CTX];
    logic [CNT_W-1:0] exec_d   [NUM_CTX];
    logic [CNT_W-1:0] squash_q [NUM_CTX];
    logic [CNT_W-1:0] squash_d [NUM_CTX];

    logic out_valid_q, out_valid_d;
    logic cond_ex_q,   cond_ex_d;
    logic pc_src_q,    pc_src_d;
    logic reg_write_q, reg_write_d;
    logic mem_write_q, mem_write_d;

    logic       ctx_ok;
    logic [3:0] cur_flags;
    logic       eval_ex;
    logic       cond_ex_comb;

    // Flag read by matching against each legal context, so an out-of-range
    // ctx_id never indexes past the flag file and simply reads as zero.
    always_comb begin
        ctx_ok    = 1'b0;
        cur_flags = '0;
        for (int c = 0; c < NUM_CTX; c++) begin
            if (ctx_id == CTX_W'(c)) begin
                ctx_ok    = 1'b1;
                cur_flags = flags_q[c];
            end
        end
    end

    cond_eval u_cond_eval (
        .cond    (cond),
        .flags   (cur_flags),
        .cond_ex (eval_ex)
    );

    assign cond_ex_comb = ctx_ok & eval_ex;
    assign flags_rd     = cur_flags;

    // Flag file next state: instruction write first, restore port last so
    // it takes priority on the same context.
    always_comb begin
        for (int c = 0; c < NUM_CTX; c++) begin
            flags_d[c] = flags_q[c];
            if (in_valid && cond_ex_comb && (ctx_id == CTX_W'(c))) begin
                flags_d[c] = apply_flag_write(flags_q[c], alu_flags, flag_w);
            end
            if (ld_en && (ld_ctx == CTX_W'(c))) begin
                flags_d[c] = ld_flags;
            end
        end
    end

    // Saturating counters; clear beats a same-cycle increment.
    always_comb begin
        for (int c = 0; c < NUM_CTX; c++) begin
            exec_d[c]   = exec_q[c];
            squash_d[c] = squash_q[c];
            if (cnt_clr) begin
                exec_d[c]   = '0;
                squash_d[c] = '0;
            end else if (in_valid && (ctx_id == CTX_W'(c))) begin
                if (cond_ex_comb) begin
                    if (exec_q[c] != CNT_MAX) exec_d[c] = exec_q[c] + CNT_W'(1);
                end else begin
                    if (squash_q[c] != CNT_MAX) squash_d[c] = squash_q[c] + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid_d = in_valid;
    assign cond_ex_d   = in_valid & cond_ex_comb;
    assign pc_src_d    = in_valid & pcs   & cond_ex_comb;
    assign reg_write_d = in_valid & reg_w & cond_ex_comb;
    assign mem_write_d = in_valid & mem_w & cond_ex_comb;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the flag file and counters are architecturally visible,
            // so unlike a plain data RAM they must be cleared on reset.
            for (int c = 0; c < NUM_CTX; c++) begin
                flags_q[c]  <= '0;
                exec_q[c]   <= '0;
                squash_q[c] <= '0;
            end
            out_valid_q <= 1'b0;
            cond_ex_q   <= 1'b0;
            pc_src_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples its
            // pre-edge inputs regardless of statement order.
            for (int c = 0; c < NUM_CTX; c++) begin
                flags_q[c]  <= flags_d[c];
                exec_q[c]   <= exec_d[c];
                squash_q[c] <= squash_d[c];
            end
            out_valid_q <= out_valid_d;
            cond_ex_q   <= cond_ex_d;
            pc_src_q    <= pc_src_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign out_valid = out_valid_q;
    assign cond_ex   = cond_ex_q;
    assign pc_src    = pc_src_q;
    assign reg_write = reg_write_q;
    assign mem_write = mem_write_q;

    for (genvar g = 0; g < NUM_CTX; g++) begin : g_pack
        assign exec_cnt[g*CNT_W +: CNT_W]   = exec_q[g];
        assign squash_cnt[g*CNT_W +: CNT_W] = squash_q[g];
    end

endmodule

// File: doc/cond_exec_unit.md
COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 SHALL have parameter NUM_CTX, default 4, meaning number of independent flag contexts (threads), minimum 1.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of each per-context executed/squashed counter.
REQ-003 SHALL have derived localparam CTX_W = max(1, $clog2(NUM_CTX)).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have in_valid  in  1  instruction present this cycle.
REQ-006 SHALL have ctx_id  in  CTX_W  context of instruction.
REQ-007 SHALL have cond  in  4  condition code.
REQ-008 SHALL have alu_flags  in  4  {N,Z,C,V} from ALU, bit3=N, bit0=V.
REQ-009 SHALL have flag_w  in  2  bit1 requests N,Z update, bit0 requests C,V update.
REQ-010 SHALL have pcs, reg_w, mem_w  in  1 each  unconditioned branch/regwrite/memwrite requests.
REQ-011 SHALL have ld_en  in  1, ld_ctx  in  CTX_W, ld_flags  in  4  direct flag restore port (context switch).
REQ-012 SHALL have cnt_clr  in  1  clear all counters.
REQ-013 SHALL have out_valid, pc_src, reg_write, mem_write, cond_ex  out  1 each  registered results.
REQ-014 SHALL have flags_rd  out  4  current flags of ctx_id (combinational from flag file).
REQ-015 SHALL have exec_cnt, squash_cnt  out  NUM_CTX*CNT_W each  packed per-context counters, context 0 in LSBs.

Function
REQ-016 SHALL hold a 4-bit flag register per context.
REQ-017 SHALL evaluate cond against the flags of ctx_id: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 treated as AL.
REQ-018 SHALL, when in_valid, at the clock edge write alu_flags[3:2] to ctx_id flags iff flag_w[1]&cond_ex_comb, and alu_flags[1:0] iff flag_w[0]&cond_ex_comb, independently.
REQ-019 SHALL register, one cycle after an in_valid cycle: out_valid=1, cond_ex=cond_ex_comb, pc_src=pcs&cond_ex_comb, reg_write=reg_w&cond_ex_comb, mem_write=mem_w&cond_ex_comb; latency exactly 1 cycle, no back-pressure.
REQ-020 SHALL drive out_valid and all four gated outputs 0 the cycle after in_valid=0.
REQ-021 SHALL make an instruction's flag update visible to the next cycle's instruction on the same context (back-to-back dependency, no bubble).
REQ-022 SHALL, when ld_en, overwrite all 4 flags of ld_ctx with ld_flags at the edge.
REQ-023 SHALL give ld_en priority over an instruction flag write to the same context in the same cycle; different contexts both write.
REQ-024 SHALL ignore ctx_id / ld_ctx values >= NUM_CTX (no flag write, no counter change; outputs still produced with cond_ex=0).
REQ-025 SHALL increment exec_cnt[ctx_id] on each in_valid cycle with cond_ex_comb=1, squash_cnt[ctx_id] otherwise; saturate at 2^CNT_W-1, never wrap.
REQ-026 SHALL clear all counters when cnt_clr; cnt_clr has priority over a same-cycle increment.

Reset
REQ-027 SHALL, while rst is high at an edge, clear all flags, counters, out_valid, cond_ex, pc_src, reg_write, mem_write to 0; rst overrides ld_en, cnt_clr and in_valid.
REQ-028 SHALL produce no output pulse for an instruction presented in a reset cycle, including reset asserted mid-stream.

Structure
REQ-029 SHALL place the condition-code enum (EQ..AL), flag bit indices (N=3,Z=2,C=1,V=0) and flag-group indices in shared package cond_pkg.
REQ-030 SHALL implement condition evaluation as combinational sub-module cond_eval (inputs cond, flags; output cond_ex).

Verification
REQ-031 SHALL cover: ctx0 flags 0000, cond=EQ, in_valid, reg_w=1 -> next cycle out_valid=1, cond_ex=0, reg_write=0, squash_cnt[0]=1.
REQ-032 SHALL cover: cycle1 ctx1 cond=AL flag_w=11 alu_flags=0100; cycle2 ctx1 cond=EQ pcs=1 -> cycle3 pc_src=1; ctx0 flags remain 0000.
REQ-033 SHALL cover: flag_w=10 alu_flags=1111 on flags 0000 -> flags 1100 (C,V untouched); then cond=GE -> cond_ex=0.
REQ-034 SHALL cover: ld_en ctx2 ld_flags=0010 same cycle as ctx2 cond=AL flag_w=11 alu_flags=1101 -> ctx2 flags=0010.
REQ-035 SHALL cover: CNT_W=2, four executed ctx0 instructions -> exec_cnt[0]=3 held; cnt_clr with in_valid same cycle -> 0.
REQ-036 SHALL cover: rst asserted with in_valid, mem_w=1, cond=AL -> next cycle mem_write=0, out_valid=0, all flags and counters 0.
